// File: rtl/frame_plot_timer_pkg.sv
// Shared defaults, coordinate widths and elaboration helpers for frame_plot_timer.
package frame_plot_timer_pkg;

   localparam int unsigned DefScrW       = 160;
   localparam int unsigned DefScrH       = 120;
   localparam int unsigned DefWaitCycles = 833334;
   localparam int unsigned DefBoxW       = 4;
   localparam int unsigned DefBoxH       = 4;

   // Fixed output coordinate widths; the parameters must fit inside them.
   localparam int unsigned WaitW  = 20;
   localparam int unsigned ScanXW = 8;
   localparam int unsigned ScanYW = 7;
   localparam int unsigned BoxXW  = 2;
   localparam int unsigned BoxYW  = 2;

   // True when values 0..n-1 are representable in w bits.
   function automatic bit fits_width(input int unsigned n, input int unsigned w);
      return (n >= 1) && (longint'(n) <= (longint'(1) << w));
   endfunction

endpackage

// File: rtl/frame_plot_timer_if.sv
// Control/status bundle between a frame sequencer (master) and the timer (slave).
interface frame_plot_timer_if;
   import frame_plot_timer_pkg::*;

   logic              reset_wait;
   logic              en_wait;
   logic              reset_plot;
   logic              en_plot;
   logic              f_wait;
   logic              f_plot;
   logic [ScanXW-1:0] scan_x;
   logic [ScanYW-1:0] scan_y;
   logic              scan_valid;
   logic [BoxXW-1:0]  box_dx;
   logic [BoxYW-1:0]  box_dy;

   modport master (
      output reset_wait, en_wait, reset_plot, en_plot,
      input  f_wait, f_plot, scan_x, scan_y, scan_valid, box_dx, box_dy
   );

   modport slave (
      input  reset_wait, en_wait, reset_plot, en_plot,
      output f_wait, f_plot, scan_x, scan_y, scan_valid, box_dx, box_dy
   );

endinterface

// File: rtl/frame_plot_timer_xy_scan_counter.sv
// Raster x/y counter: x runs fastest, saturates at (W-1, H-1) until cleared.
module xy_scan_counter #(
   parameter int unsigned W  = 4,
   parameter int unsigned H  = 4,
   parameter int unsigned XW = 2,
   parameter int unsigned YW = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear_ni,
   input  logic          en_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_end;

   assign x_end  = (x_q == XW'(W - 1));
   assign last_o = x_end && (y_q == YW'(H - 1));
   assign x_o    = x_q;
   assign y_o    = y_q;

   // Next position: clear wins, otherwise step in raster order and park on the last cell.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!clear_ni) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i && !last_o) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // Position registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/frame_plot_timer.sv
// Frame-wait timer with screen raster scan, plus an independent sprite pixel scanner.
module frame_plot_timer
   import frame_plot_timer_pkg::*;
#(
   parameter int unsigned SCR_W       = DefScrW,
   parameter int unsigned SCR_H       = DefScrH,
   parameter int unsigned WAIT_CYCLES = DefWaitCycles,
   parameter int unsigned BOX_W       = DefBoxW,
   parameter int unsigned BOX_H       = DefBoxH
) (
   input logic               clk,
   input logic               reset_n,
   frame_plot_timer_if.slave tmr_io
);

   localparam int unsigned ScrPixels = SCR_W * SCR_H;

   if (WAIT_CYCLES < ScrPixels) begin : g_bad_wait
      $error("WAIT_CYCLES must be at least SCR_W*SCR_H");
   end
   if (!fits_width(WAIT_CYCLES, WaitW)) begin : g_bad_wait_w
      $error("WAIT_CYCLES does not fit the wait counter");
   end
   if (!fits_width(SCR_W, ScanXW) || !fits_width(SCR_H, ScanYW)) begin : g_bad_scr
      $error("screen size does not fit scan_x/scan_y");
   end
   if (!fits_width(BOX_W, BoxXW) || !fits_width(BOX_H, BoxYW)) begin : g_bad_box
      $error("sprite size does not fit box_dx/box_dy");
   end

   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             wait_last;
   logic             wait_wrap;
   logic             plot_last;
   logic             plot_wrap;

   assign wait_last = (wait_cnt_q == WaitW'(WAIT_CYCLES - 1));
   assign wait_wrap = tmr_io.en_wait && wait_last;
   assign plot_wrap = tmr_io.en_plot && plot_last;

   // Flags are suppressed while the block is held in reset.
   assign tmr_io.f_wait     = reset_n && tmr_io.reset_wait && wait_wrap;
   assign tmr_io.f_plot     = reset_n && tmr_io.reset_plot && plot_wrap;
   assign tmr_io.scan_valid = (wait_cnt_q < WaitW'(ScrPixels));

   // Wait counter next state: clear, wrap at the period end, else count enabled cycles.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!tmr_io.reset_wait) begin
         wait_cnt_d = '0;
      end else if (tmr_io.en_wait) begin
         wait_cnt_d = wait_last ? '0 : wait_cnt_q + WaitW'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Screen scan follows the wait counter; the period wrap returns it to the origin.
   xy_scan_counter #(
      .W  (SCR_W),
      .H  (SCR_H),
      .XW (ScanXW),
      .YW (ScanYW)
   ) u_screen_scan (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_ni (tmr_io.reset_wait && !wait_wrap),
      .en_i     (tmr_io.en_wait),
      .x_o      (tmr_io.scan_x),
      .y_o      (tmr_io.scan_y),
      .last_o   ()
   );

   // Sprite scan wraps immediately after its last pixel.
   xy_scan_counter #(
      .W  (BOX_W),
      .H  (BOX_H),
      .XW (BoxXW),
      .YW (BoxYW)
   ) u_box_scan (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_ni (tmr_io.reset_plot && !plot_wrap),
      .en_i     (tmr_io.en_plot),
      .x_o      (tmr_io.box_dx),
      .y_o      (tmr_io.box_dy),
      .last_o   (plot_last)
   );

endmodule

// File: tb/tb_frame_plot_timer.sv
// Randomised scoreboard bench for frame_plot_timer with a count-based reference model.
module tb_frame_plot_timer;

   localparam int unsigned SW = 4;
   localparam int unsigned SH = 3;
   localparam int unsigned WC = 16;
   localparam int unsigned BW = 2;
   localparam int unsigned BH = 2;

   typedef struct {
      logic       fw;
      logic       fp;
      logic       sv;
      logic [7:0] sx;
      logic [6:0] sy;
      logic [1:0] dx;
      logic [1:0] dy;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   errors = 0;
   int   w = 0;   // model: enabled cycles into the current wait period
   int   p = 0;   // model: linear sprite pixel index
   exp_t sb[$];

   frame_plot_timer_if bus ();

   frame_plot_timer #(
      .SCR_W       (SW),
      .SCR_H       (SH),
      .WAIT_CYCLES (WC),
      .BOX_W       (BW),
      .BOX_H       (BH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tmr_io  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("f_wait",     32'(bus.f_wait),     32'(e.fw));
         check("f_plot",     32'(bus.f_plot),     32'(e.fp));
         check("scan_valid", 32'(bus.scan_valid), 32'(e.sv));
         check("scan_x",     32'(bus.scan_x),     32'(e.sx));
         check("scan_y",     32'(bus.scan_y),     32'(e.sy));
         check("box_dx",     32'(bus.box_dx),     32'(e.dx));
         check("box_dy",     32'(bus.box_dy),     32'(e.dy));
      end
   end

   // Drive one cycle of inputs, push the expected response, then advance the model.
   task automatic step(input logic rn, input logic rw, input logic ew,
                       input logic rp, input logic ep);
      exp_t e;
      int   idx;
      @(posedge clk);
      #1;
      reset_n        = rn;
      bus.reset_wait = rw;
      bus.en_wait    = ew;
      bus.reset_plot = rp;
      bus.en_plot    = ep;
      idx  = (w < int'(SW * SH)) ? w : int'(SW * SH) - 1;
      e.sx = 8'(idx % SW);
      e.sy = 7'(idx / SW);
      e.sv = (w < int'(SW * SH));
      e.dx = 2'(p % BW);
      e.dy = 2'(p / BW);
      e.fw = rn && rw && ew && (w == int'(WC) - 1);
      e.fp = rn && rp && ep && (p == int'(BW * BH) - 1);
      sb.push_back(e);
      if (!rn) begin
         w = 0;
         p = 0;
      end else begin
         if (!rw)      w = 0;
         else if (ew)  w = (w + 1) % int'(WC);
         if (!rp)      p = 0;
         else if (ep)  p = (p + 1) % int'(BW * BH);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.reset_wait = 1'b1;
      bus.en_wait    = 1'b0;
      bus.reset_plot = 1'b1;
      bus.en_plot    = 1'b0;
      @(posedge clk);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      // Both sides free-running: flags align every 16 cycles.
      for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      // Wait side enabled every other cycle.
      for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 1'(i % 2 == 0), 1'b1, 1'b0);
      // Clear the wait side mid-period while enabled.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      // Global reset at wait count 14 with the sprite at its last pixel.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'(i < 3));
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(63, 0) != 0),
              1'($urandom_range(19, 0) != 0),
              1'($urandom_range(3, 0) != 0),
              1'($urandom_range(15, 0) != 0),
              1'($urandom_range(1, 0)));
      end
      repeat (3) @(posedge clk);
      tests++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
